// File: rtl/zx48_pkg.sv
// rtl/zx48_pkg.sv - shared state encoding and write-cycle length for mem_loader
// LOADER_VERIFY_EN adds the read-back states V1..V3.
package zx48_pkg;

    localparam int STATE_W   = 4;
    localparam int CYCLE_LEN = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 4'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 4'd1;
    localparam logic [STATE_W-1:0] ST_WAIT = 4'd2;
    localparam logic [STATE_W-1:0] ST_T1   = 4'd3;
    localparam logic [STATE_W-1:0] ST_T2   = 4'd4;
    // The write cycle occupies CYCLE_LEN consecutive codes starting at T1.
    localparam logic [STATE_W-1:0] ST_T3   = ST_T1 + 4'(CYCLE_LEN - 1);
    localparam logic [STATE_W-1:0] ST_NEXT = 4'd6;
    localparam logic [STATE_W-1:0] ST_REL  = 4'd7;
`ifdef LOADER_VERIFY_EN
    localparam logic [STATE_W-1:0] ST_V1   = 4'd8;
    localparam logic [STATE_W-1:0] ST_V2   = 4'd9;
    localparam logic [STATE_W-1:0] ST_V3   = 4'd10;
`endif

endpackage

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - streams bytes into CPU memory via Z80-style write cycles after bus request
// LOADER_VERIFY_EN adds a read-back of each byte and a sticky err flag.
module mem_loader
    import zx48_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic [15:0] base,
    input  logic [15:0] len,
    input  logic [7:0]  sD,
    input  logic        sValid,
    output logic        sReady,
    output logic        busrq,
    input  logic        busak,
    output logic        mreq,
    output logic        wr,
    output logic        rd,
    output logic [15:0] a,
    output logic [7:0]  d,
    input  logic [7:0]  q,
    output logic        busy,
    output logic        done,
    output logic        err
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic [15:0]        count;
    logic               take;

    // A byte is only taken while the bus is still granted.
    assign take = sValid && !busak;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start && (len != 16'd0)) state_nx = ST_REQ;
            ST_REQ:  if (!busak) state_nx = ST_WAIT;
            ST_WAIT: if (take) state_nx = ST_T1;
            ST_T1:   state_nx = ST_T2;
            ST_T2:   state_nx = ST_T3;
`ifdef LOADER_VERIFY_EN
            ST_T3:   state_nx = ST_V1;
            ST_V1:   state_nx = ST_V2;
            ST_V2:   state_nx = ST_V3;
            ST_V3:   state_nx = ST_NEXT;
`else
            ST_T3:   state_nx = ST_NEXT;
`endif
            ST_NEXT: state_nx = (count == 16'd1) ? ST_REL : ST_WAIT;
            ST_REL:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
            a     <= 16'h0000;
            d     <= 8'h00;
            count <= 16'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ce) begin
                state <= state_nx;
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (len != 16'd0) begin
                                a     <= base;
                                count <= len;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT: if (take) d <= sD;
                    ST_NEXT: begin
                        a     <= a + 16'd1;
                        count <= count - 16'd1;
                    end
                    ST_REL:  done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (ce) begin
            if ((state == ST_IDLE) && start) begin
                err <= 1'b0;
            end else if ((state == ST_V3) && (q != d)) begin
                err <= 1'b1;
            end
        end
    end

    assign mreq = !((state == ST_T2) || (state == ST_T3) ||
                    (state == ST_V2) || (state == ST_V3));
    assign rd   = !((state == ST_V2) || (state == ST_V3));
`else
    logic unused_q;
    assign unused_q = ^q;

    assign err  = 1'b0;
    assign mreq = !((state == ST_T2) || (state == ST_T3));
    assign rd   = 1'b1;
`endif

    assign wr     = !((state == ST_T2) || (state == ST_T3));
    // ce is folded in so that sValid && sReady alone marks a consumed byte.
    assign sReady = (state == ST_WAIT) && ce && !busak;
    assign busrq  = (state == ST_IDLE) || (state == ST_REL);
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - randomized self-checking bench for mem_loader with a memory/bus model
// Build with LOADER_VERIFY_EN to exercise the read-back path.
module tb_mem_loader;
    import zx48_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base = 16'h0000;
    logic [15:0] len = 16'h0000;
    logic [7:0]  sD = 8'h00;
    logic        sValid = 1'b0;
    logic        sReady;
    logic        busrq;
    logic        busak = 1'b1;
    logic        mreq, wr, rd;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        busy, done, err;

    mem_loader dut (
        .clock(clock), .reset(reset), .ce(ce), .start(start), .base(base), .len(len),
        .sD(sD), .sValid(sValid), .sReady(sReady), .busrq(busrq), .busak(busak),
        .mreq(mreq), .wr(wr), .rd(rd), .a(a), .d(d), .q(q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

`ifdef LOADER_VERIFY_EN
    localparam int SETTLE = 8;
`else
    localparam int SETTLE = 5;
`endif

    int n_tests = 0;
    int n_fail = 0;

    // Memory model: a read returns what was written, optionally corrupted at one address.
    logic [7:0]  mem_model [0:65535];
    bit          corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = 16'h0000;
    assign q = mem_model[a] ^ ((corrupt_en && (a == corrupt_addr)) ? 8'h5A : 8'h00);

    logic [15:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    int          wr_lens[$];
    bit          err_at[$];
    int          cur_len = 0;
    int          done_cnt = 0;
    int          brq_low_cnt = 0;
    int          mreq_low_cnt = 0;
    int          rd_low_cnt = 0;
    int          err_cnt = 0;
    bit          prev_wr = 1'b1;

    always @(negedge clock) begin
        if (prev_wr && (wr === 1'b0)) begin
            wq_addr.push_back(a);
            wq_data.push_back(d);
            err_at.push_back(err);
            mem_model[a] = d;
            cur_len = 0;
        end
        if ((wr === 1'b0) && ce) cur_len++;
        if (!prev_wr && (wr === 1'b1)) wr_lens.push_back(cur_len);
        prev_wr = (wr !== 1'b0);
        if (done === 1'b1) done_cnt++;
        if (busrq === 1'b0) brq_low_cnt++;
        if (mreq === 1'b0) mreq_low_cnt++;
        if (rd === 1'b0) rd_low_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    logic [7:0] src_q[$];
    int g_n, g_idx, g_gdelay, g_gcnt, g_stall_at, g_stall, g_stall_age;
    int g_drop_at, g_drop;
    bit g_dropped, g_rand_ce, g_poke, g_poked, stall_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_src(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
    endtask

    // One clock of stream source and bus arbiter behaviour.
    task automatic tick();
        bit acc, brq, ce_s;
        @(negedge clock);
        acc  = sValid && sReady;
        brq  = busrq;
        ce_s = ce;
        if (g_stall > 0) begin
            g_stall_age++;
            if (g_stall_age >= SETTLE && !(mreq && wr && rd && sReady && busy)) stall_bad = 1'b1;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        if (acc) begin
            g_idx++;
            if (g_idx == g_stall_at) begin
                g_stall = 10;
                g_stall_age = 0;
            end
        end else if ((g_stall > 0) && ce_s) begin
            g_stall--;
        end
        if (!brq) begin
            if (ce_s) g_gcnt++;
        end else begin
            g_gcnt = 0;
        end
        if ((g_drop_at >= 0) && (g_idx == g_drop_at) && !g_dropped) begin
            g_dropped = 1'b1;
            g_drop = 6;
        end
        if (g_drop > 0) begin
            busak = 1'b1;
            g_drop--;
        end else begin
            busak = !(!brq && (g_gcnt >= g_gdelay));
        end
        sValid = (g_idx < g_n) && (g_stall == 0);
        sD     = (g_idx < g_n) ? src_q[g_idx] : 8'h00;
        ce     = g_rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (g_poke && !g_poked && (g_idx == 1)) begin
            start = 1'b1;
            base  = 16'h1234;
            len   = 16'd7;
            g_poked = 1'b1;
        end
    endtask

    task automatic start_xfer(input logic [15:0] b, input int n, input int gdelay, input bit rand_ce,
                              input int stall_at, input int drop_at, input bit poke);
        g_n = n; g_idx = 0; g_gdelay = gdelay; g_gcnt = 0;
        g_stall_at = stall_at; g_stall = 0; g_stall_age = 0;
        g_drop_at = drop_at; g_drop = 0; g_dropped = 1'b0;
        g_rand_ce = rand_ce; g_poke = poke; g_poked = 1'b0; stall_bad = 1'b0;
        @(posedge clock);
        #1;
        base = b; len = 16'(n); start = 1'b1; ce = 1'b1; sValid = 1'b0; busak = 1'b1;
    endtask

    task automatic run_xfer(input logic [15:0] b, input int n, input int gdelay, input bit rand_ce,
                            input int stall_at, input int drop_at, input bit poke, input bit clean);
        int w0, l0, d0, brq0, mreq0, rd0, err0, cyc, post, bad_len;
        w0 = wq_addr.size(); l0 = wr_lens.size(); d0 = done_cnt;
        brq0 = brq_low_cnt; mreq0 = mreq_low_cnt; rd0 = rd_low_cnt; err0 = err_cnt;
        start_xfer(b, n, gdelay, rand_ce, stall_at, drop_at, poke);
        cyc = 0; post = 0;
        while ((cyc < 4000) && (post < 3)) begin
            tick();
            cyc++;
            if (done_cnt != d0) post++;
        end
        check("done_pulses", done_cnt - d0, 1);
        check("write_count", wq_addr.size() - w0, n);
        for (int i = 0; i < n; i++) begin
            if (w0 + i < wq_addr.size()) begin
                check("write_addr", wq_addr[w0 + i], 16'(b + i));
                check("write_data", wq_data[w0 + i], src_q[i]);
            end
        end
        bad_len = 0;
        for (int i = l0; i < wr_lens.size(); i++)
            if (wr_lens[i] != CYCLE_LEN - 1) bad_len++;
        check("wr_low_len", bad_len, 0);
        check("busrq_after", busrq, 1'b1);
        check("busy_after", busy, 1'b0);
        if (n == 0) begin
            check("busrq_never_low", brq_low_cnt - brq0, 0);
            check("no_strobes", mreq_low_cnt - mreq0, 0);
        end else begin
            check("a_after", a, 16'(b + n));
            check("d_after", d, src_q[n - 1]);
        end
`ifdef LOADER_VERIFY_EN
        check("rd_activity", (rd_low_cnt - rd0) != 0, n != 0);
`else
        check("rd_idle", rd_low_cnt - rd0, 0);
`endif
        if (clean) check("err_clean", err_cnt - err0, 0);
        if (stall_at >= 0) check("stall_strobes", stall_bad, 1'b0);
    endtask

    initial begin
        int w0, cyc, n, e0;
        logic [15:0] b;

        g_stall_at = -1; g_drop_at = -1;
        repeat (3) @(negedge clock);
        check("rst_busrq", busrq, 1'b1);
        check("rst_mreq", mreq, 1'b1);
        check("rst_wr", wr, 1'b1);
        check("rst_rd", rd, 1'b1);
        check("rst_sReady", sReady, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_a", a, 16'h0000);
        check("rst_d", d, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        src_q.delete();
        src_q.push_back(8'hAA); src_q.push_back(8'h55); src_q.push_back(8'hFF);
        run_xfer(16'h4000, 3, 2, 1'b0, -1, -1, 1'b0, 1'b1);

        fill_src(2);
        run_xfer(16'hFFFF, 2, 1, 1'b0, -1, -1, 1'b0, 1'b1);

        src_q.delete();
        run_xfer(16'h3000, 0, 1, 1'b0, -1, -1, 1'b0, 1'b1);

        fill_src(6);
        run_xfer(16'h8000, 6, 1, 1'b0, 3, -1, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            b = 16'($urandom);
            n = $urandom_range(1, 8);
            fill_src(n);
            run_xfer(b, n, $urandom_range(1, 4), k[0], -1,
                     (k >= 3) ? $urandom_range(1, n) : -1, k == 2, 1'b1);
        end

        fill_src(4);
        w0 = wq_addr.size();
        start_xfer(16'h5000, 4, 1, 1'b0, -1, -1, 1'b0);
        cyc = 0;
        while ((wq_addr.size() == w0) && (cyc < 200)) begin
            tick();
            cyc++;
        end
        check("mid_write_reached", wq_addr.size() > w0, 1'b1);
        check("wr_low_before_reset", wr, 1'b0);
        reset = 1'b0;
        sValid = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mid_mreq", mreq, 1'b1);
        check("rst_mid_wr", wr, 1'b1);
        check("rst_mid_busrq", busrq, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_a", a, 16'h0000);
        reset = 1'b1;
        busak = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        fill_src(3);
        run_xfer(16'h6000, 3, 2, 1'b1, -1, -1, 1'b0, 1'b1);

`ifdef LOADER_VERIFY_EN
        corrupt_addr = 16'h2001;
        corrupt_en = 1'b1;
        fill_src(4);
        e0 = err_at.size();
        run_xfer(16'h2000, 4, 2, 1'b0, -1, -1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            check("verify_err_progress", err_at[e0 + i], i >= 2);
        check("verify_err_final", err, 1'b1);
        corrupt_en = 1'b0;
        fill_src(3);
        e0 = err_at.size();
        run_xfer(16'h2000, 3, 1, 1'b0, -1, -1, 1'b0, 1'b1);
        check("verify_err_cleared_at_start", err_at[e0], 1'b0);
        check("verify_err_cleared", err, 1'b0);
`else
        e0 = 0;
        check("err_const", err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have these ports: clock  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low.
REQ-003 SHALL have: ce  in  1  clock enable; the FSM and counters advance only when ce=1.
REQ-004 SHALL have: start  in  1  one-cycle request, sampled in IDLE.
REQ-005 SHALL have: base  in  16  first target address. len  in  16  byte count; 0 means no transfer.
REQ-006 SHALL have: sD  in  8  stream byte. sValid  in  1  byte offered. sReady  out  1  byte accepted.
REQ-007 SHALL have: busrq  out  1  active-low CPU bus request. busak  in  1  active-low CPU bus grant.
REQ-008 SHALL have: mreq, wr, rd  out  1 each  active-low memory strobes, Z80 cycle style.
REQ-009 SHALL have: a  out  16  address. d  out  8  write data. q  in  8  read data from memory.
REQ-010 SHALL have: busy  out  1  transfer in progress. done  out  1  one-cycle completion pulse. err  out  1  sticky verify error.

Function
REQ-011 SHALL use states IDLE, REQ, WAIT, T1, T2, T3, NEXT, REL, with V1, V2, V3 added when verify is compiled in.
REQ-012 IDLE: on start=1 with len!=0, SHALL latch base into the address counter and len into the count, clear err, and go to REQ.
REQ-013 IDLE: on start=1 with len=0, SHALL pulse done on the next ce cycle, leave busrq high, and remain in IDLE.
REQ-014 REQ: SHALL drive busrq=0 and hold until busak=0, then go to WAIT; busrq SHALL stay 0 until REL.
REQ-015 WAIT: SHALL hold sReady=1; on sValid=1 in a ce cycle, SHALL capture sD into the d register and go to T1. sReady SHALL be 0 in all other states.
REQ-016 T1: a SHALL be valid and mreq=wr=rd=1.
REQ-017 T2 and T3: SHALL drive mreq=0 and wr=0 with d stable.
REQ-018 NEXT: SHALL drive mreq=wr=1, increment the address, and decrement the count.
REQ-018a NEXT: the address SHALL wrap from FFFF to 0000.
REQ-019 NEXT: if the count reaches 0, SHALL go to REL; otherwise SHALL go to WAIT.
REQ-020 Each write cycle SHALL last exactly 3 ce cycles (T1, T2, T3) plus NEXT, so wr is low for exactly 2 ce cycles.
REQ-021 REL: SHALL drive busrq=1, pulse done for one clock, and return to IDLE. busy SHALL be 1 in every state other than IDLE.
REQ-022 Outside bus ownership (IDLE, REQ), mreq, wr and rd SHALL be 1; a and d SHALL hold their last values.
REQ-023 If busak returns to 1 during a transfer, SHALL finish the current cycle, then wait in WAIT with sReady=0 until busak=0 again.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 If sValid drops during WAIT, the FSM SHALL stall with no bus strobes asserted.

Reset
REQ-026 When reset=0 at a clock edge, SHALL go to IDLE regardless of ce, in any state, including mid-cycle.
REQ-027 Reset values: busrq=1, mreq=1, wr=1, rd=1, sReady=0, busy=0, done=0, err=0, a=0000, d=00, count=0.
REQ-028 A reset during T2/T3 SHALL deassert the strobes on that same edge; no partial-write recovery is required.

Configuration
REQ-029 Macro LOADER_VERIFY_EN. When defined, after T3 the FSM SHALL run V1 (mreq=wr=rd=1), V2 (mreq=0, rd=0), and V3 (mreq=0, rd=0, sample q), then go to NEXT.
REQ-029a With LOADER_VERIFY_EN, if q != d at V3, err SHALL set and remain set until the next accepted start.
REQ-030 Without LOADER_VERIFY_EN, rd SHALL be constant 1, err constant 0, and the V states SHALL not exist.

Structure
REQ-031 SHALL place the state encoding (localparam/typedef, 4 bits) and the cycle-length constant (3) in shared package zx48_pkg.
REQ-032 SHALL be a single module with no sub-modules; the address/count counters SHALL be inline.

Verification
REQ-033 base=4000, len=3, stream AA,55,FF, busak granted 2 ce after busrq -> writes 4000=AA, 4001=55, 4002=FF; 3 wr pulses, each 2 ce long; one done pulse; busrq high after.
REQ-034 base=FFFF, len=2 -> writes at FFFF then 0000 (address wrap).
REQ-035 len=0, start -> done pulses once, busrq never asserted, no strobes.
REQ-036 sValid withheld 10 ce mid-transfer -> FSM stalls in WAIT, strobes high, transfer resumes intact.
REQ-037 reset=0 asserted during T2 -> next edge shows mreq=wr=busrq=1, busy=0.
REQ-038 LOADER_VERIFY_EN, memory model corrupts byte 1 -> err=1 after that byte; transfer completes; next start clears err.
